// File: rtl/decoder_3_to_8_if.sv
// Select/strobe bus for decoder_3_to_8: enable plus 3-bit select in, one-hot lines out.
// With DECODER_3_TO_8_SEEN_EN defined the bus also carries the sticky coverage mask.
interface decoder_3_to_8_if;
  logic       en;
  logic       a;
  logic       b;
  logic       c;
  logic [7:0] y;
  logic       valid;
`ifdef DECODER_3_TO_8_SEEN_EN
  logic       seen_clr;
  logic [7:0] seen;
`endif

`ifdef DECODER_3_TO_8_SEEN_EN
  modport master (output en, a, b, c, seen_clr, input y, valid, seen);
  modport slave  (input en, a, b, c, seen_clr, output y, valid, seen);
`else
  modport master (output en, a, b, c, input y, valid);
  modport slave  (input en, a, b, c, output y, valid);
`endif
endinterface

// File: rtl/decoder_3_to_8.sv
// Registered 3-to-8 decoder with enable and selectable output polarity (one-cycle latency).
// Optional sticky code-coverage mask enabled by defining DECODER_3_TO_8_SEEN_EN.
module decoder_3_to_8 #(
  parameter bit ACTIVE_LOW = 1'b0
) (
  input logic              clk,
  input logic              rst,
  decoder_3_to_8_if.slave  bus
);

  localparam logic [7:0] IDLE = ACTIVE_LOW ? 8'hFF : 8'h00;

  function automatic logic [7:0] onehot(input logic [2:0] sel);
    onehot = 8'h01 << sel;
  endfunction

  logic [2:0] sel_s;
  logic [7:0] onehot_s;
  logic [7:0] decoded_s;
  logic [7:0] y_r;
  logic       valid_r;

  // Select assembly and polarity-adjusted decode of the current inputs
  always_comb begin
    sel_s     = {bus.a, bus.b, bus.c};
    onehot_s  = onehot(sel_s);
    decoded_s = onehot_s;
    if (ACTIVE_LOW) begin
      decoded_s = onehot_s ^ 8'hFF;
    end else begin
      decoded_s = onehot_s;
    end
  end

  // Output register: idle value whenever not decoding, so nothing is held over
  always_ff @(posedge clk) begin
    if (rst) begin
      y_r     <= IDLE;
      valid_r <= 1'b0;
    end else if (bus.en) begin
      y_r     <= decoded_s;
      valid_r <= 1'b1;
    end else begin
      y_r     <= IDLE;
      valid_r <= 1'b0;
    end
  end

  assign bus.y     = y_r;
  assign bus.valid = valid_r;

`ifdef DECODER_3_TO_8_SEEN_EN
  logic [7:0] seen_r;

  // Sticky coverage mask; a clear on a decode edge keeps that edge's code
  always_ff @(posedge clk) begin
    if (rst) begin
      seen_r <= 8'h00;
    end else if (bus.en) begin
      seen_r <= (bus.seen_clr ? 8'h00 : seen_r) | onehot_s;
    end else if (bus.seen_clr) begin
      seen_r <= 8'h00;
    end else begin
      seen_r <= seen_r;
    end
  end

  assign bus.seen = seen_r;
`endif

endmodule

// File: tb/tb_decoder_3_to_8.sv
// Self-checking bench for decoder_3_to_8: directed scenarios plus randomized traffic
// against a behavioural model, on an active-high and an active-low instance.
module tb_decoder_3_to_8;

  logic clk = 1'b0;
  logic rst;
  always #10 clk = ~clk;

  decoder_3_to_8_if hi_if ();
  decoder_3_to_8_if lo_if ();

  decoder_3_to_8 #(.ACTIVE_LOW(1'b0)) dut_hi (.clk(clk), .rst(rst), .bus(hi_if.slave));
  decoder_3_to_8 #(.ACTIVE_LOW(1'b1)) dut_lo (.clk(clk), .rst(rst), .bus(lo_if.slave));

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [7:0] exp_hi;
  logic [7:0] exp_lo;
  logic       exp_valid;
  bit         seen_m [8];

  function automatic logic [7:0] seen_vec();
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = seen_m[i];
    return v;
  endfunction

  // Apply one cycle of inputs, advance the model, wait past the edge.
  task automatic drive(input logic r, input logic e, input int s, input logic clr);
    logic [2:0] sv;
    sv = 3'(s);
    rst = r;
    hi_if.en = e; {hi_if.a, hi_if.b, hi_if.c} = sv;
    lo_if.en = e; {lo_if.a, lo_if.b, lo_if.c} = sv;
`ifdef DECODER_3_TO_8_SEEN_EN
    hi_if.seen_clr = clr;
    lo_if.seen_clr = clr;
`endif
    if (r) begin
      exp_hi = 8'h00; exp_lo = 8'hFF; exp_valid = 1'b0;
      for (int i = 0; i < 8; i++) seen_m[i] = 1'b0;
    end else begin
      if (clr) for (int i = 0; i < 8; i++) seen_m[i] = 1'b0;
      if (e) begin
        exp_hi = 8'(2 ** s);
        exp_lo = 8'(255 - 2 ** s);
        exp_valid = 1'b1;
        seen_m[s] = 1'b1;
      end else begin
        exp_hi = 8'h00; exp_lo = 8'hFF; exp_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 5, 1'b0);
    drive(1'b1, 1'b1, 5, 1'b0);
    total_cnt++; if (hi_if.y !== 8'h00) $display("FAIL reset_y got %h want 00", hi_if.y); else pass_cnt++;
    total_cnt++; if (hi_if.valid !== 1'b0) $display("FAIL reset_valid got %b want 0", hi_if.valid); else pass_cnt++;
    total_cnt++; if (lo_if.y !== 8'hFF) $display("FAIL reset_y_low got %h want FF", lo_if.y); else pass_cnt++;
    total_cnt++; if (lo_if.valid !== 1'b0) $display("FAIL reset_valid_low got %b want 0", lo_if.valid); else pass_cnt++;
    drive(1'b0, 1'b1, 5, 1'b0);
    total_cnt++; if (hi_if.y !== 8'h20) $display("FAIL release_y got %h want 20", hi_if.y); else pass_cnt++;
    total_cnt++; if (hi_if.valid !== 1'b1) $display("FAIL release_valid got %b want 1", hi_if.valid); else pass_cnt++;
  endtask

  task automatic test_sweep();
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, i, 1'b0);
      total_cnt++; if (hi_if.y !== exp_hi) $display("FAIL sweep_y code %0d got %h want %h", i, hi_if.y, exp_hi); else pass_cnt++;
      total_cnt++; if (lo_if.y !== exp_lo) $display("FAIL sweep_y_low code %0d got %h want %h", i, lo_if.y, exp_lo); else pass_cnt++;
      total_cnt++; if (hi_if.valid !== 1'b1) $display("FAIL sweep_valid code %0d got %b want 1", i, hi_if.valid); else pass_cnt++;
    end
  endtask

  // Each code held for 200 time units (10 cycles); output must stay put.
  task automatic test_held_sweep();
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 10; k++) begin
        drive(1'b0, 1'b1, i, 1'b0);
        total_cnt++; if (hi_if.y !== exp_hi || hi_if.valid !== 1'b1)
          $display("FAIL held_y code %0d got %h/%b want %h/1", i, hi_if.y, hi_if.valid, exp_hi); else pass_cnt++;
      end
    end
  endtask

  task automatic test_enable_gating();
    drive(1'b0, 1'b1, 3, 1'b0);
    total_cnt++; if (hi_if.y !== 8'h08) $display("FAIL gate_decode got %h want 08", hi_if.y); else pass_cnt++;
    drive(1'b0, 1'b0, 3, 1'b0);
    total_cnt++; if (hi_if.y !== 8'h00) $display("FAIL gate_idle_y got %h want 00", hi_if.y); else pass_cnt++;
    total_cnt++; if (hi_if.valid !== 1'b0) $display("FAIL gate_idle_valid got %b want 0", hi_if.valid); else pass_cnt++;
    drive(1'b0, 1'b1, 6, 1'b0);
    total_cnt++; if (hi_if.y !== 8'h40) $display("FAIL gate_resume got %h want 40", hi_if.y); else pass_cnt++;
  endtask

  task automatic test_active_low();
    drive(1'b1, 1'b0, 0, 1'b0);
    total_cnt++; if (lo_if.y !== 8'hFF) $display("FAIL low_reset got %h want FF", lo_if.y); else pass_cnt++;
    drive(1'b0, 1'b1, 0, 1'b0);
    total_cnt++; if (lo_if.y !== 8'hFE) $display("FAIL low_code0 got %h want FE", lo_if.y); else pass_cnt++;
    drive(1'b0, 1'b1, 7, 1'b0);
    total_cnt++; if (lo_if.y !== 8'h7F) $display("FAIL low_code7 got %h want 7F", lo_if.y); else pass_cnt++;
    drive(1'b0, 1'b0, 7, 1'b0);
    total_cnt++; if (lo_if.y !== 8'hFF) $display("FAIL low_idle got %h want FF", lo_if.y); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 8; i++) begin
      drive(i == 4, 1'b1, i, 1'b0);
      if (i == 4) begin
        total_cnt++; if (hi_if.y !== 8'h00 || hi_if.valid !== 1'b0)
          $display("FAIL mid_reset got %h/%b want 00/0", hi_if.y, hi_if.valid); else pass_cnt++;
      end else begin
        total_cnt++; if (hi_if.y !== exp_hi || hi_if.valid !== 1'b1)
          $display("FAIL mid_sweep code %0d got %h/%b want %h/1", i, hi_if.y, hi_if.valid, exp_hi); else pass_cnt++;
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      drive($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0,
            int'($urandom_range(0, 7)), $urandom_range(0, 15) == 0);
      total_cnt++; if (hi_if.y !== exp_hi || hi_if.valid !== exp_valid)
        $display("FAIL rand_hi cyc %0d got %h/%b want %h/%b", n, hi_if.y, hi_if.valid, exp_hi, exp_valid); else pass_cnt++;
      total_cnt++; if (lo_if.y !== exp_lo || lo_if.valid !== exp_valid)
        $display("FAIL rand_lo cyc %0d got %h/%b want %h/%b", n, lo_if.y, lo_if.valid, exp_lo, exp_valid); else pass_cnt++;
`ifdef DECODER_3_TO_8_SEEN_EN
      total_cnt++; if (hi_if.seen !== seen_vec() || lo_if.seen !== seen_vec())
        $display("FAIL rand_seen cyc %0d got %h/%h want %h", n, hi_if.seen, lo_if.seen, seen_vec()); else pass_cnt++;
`endif
    end
  endtask

`ifdef DECODER_3_TO_8_SEEN_EN
  task automatic test_seen();
    drive(1'b1, 1'b0, 0, 1'b0);
    total_cnt++; if (hi_if.seen !== 8'h00) $display("FAIL seen_reset got %h want 00", hi_if.seen); else pass_cnt++;
    drive(1'b0, 1'b1, 0, 1'b0);
    drive(1'b0, 1'b1, 2, 1'b0);
    drive(1'b0, 1'b1, 7, 1'b0);
    total_cnt++; if (hi_if.seen !== 8'h85) $display("FAIL seen_partial got %h want 85", hi_if.seen); else pass_cnt++;
    total_cnt++; if (lo_if.seen !== 8'h85) $display("FAIL seen_partial_low got %h want 85", lo_if.seen); else pass_cnt++;
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, i, 1'b0);
    total_cnt++; if (hi_if.seen !== 8'hFF) $display("FAIL seen_full got %h want FF", hi_if.seen); else pass_cnt++;
    drive(1'b0, 1'b1, 1, 1'b1);
    total_cnt++; if (hi_if.seen !== 8'h02) $display("FAIL seen_clr got %h want 02", hi_if.seen); else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_sweep();
    test_held_sweep();
    test_enable_gating();
    test_active_low();
    test_reset_mid();
`ifdef DECODER_3_TO_8_SEEN_EN
    test_seen();
`endif
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/decoder_3_to_8.md
Name: decoder_3_to_8

Overview:
- Registered 3-to-8 line decoder with active-high enable.
- Converts a 3-bit select {a,b,c} (a = MSB) into a one-hot 8-bit word: y[i] is asserted when {a,b,c} == i.
- Output is registered on clk with one-cycle latency.
- Used as a generic select/strobe generator wherever a binary index must drive eight individual lines.

Parameters:
- ACTIVE_LOW, default 0: output polarity.
  - 0: selected line = 1, others = 0.
  - 1: selected line = 0, others = 1. The whole y vector is inverted, including the reset and idle values.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- en  input  1  decode enable, sampled on the clk rising edge.
- a  input  1  select bit 2 (MSB).
- b  input  1  select bit 1.
- c  input  1  select bit 0 (LSB).
- y  output  8  registered decoded lines; y[0] corresponds to code 000, y[7] to code 111.
- valid  output  1  registered; high when y holds a decoded value.

Behaviour:
- All state updates occur on the clk rising edge only. There are no combinational paths from inputs to outputs.
- Reset: when rst = 1 at an edge:
  - y <= IDLE, where IDLE = 8'h00 if ACTIVE_LOW = 0, 8'hFF if ACTIVE_LOW = 1.
  - valid <= 0.
  - rst has priority over en and all other inputs.
- Decode: when rst = 0 and en = 1 at an edge:
  - Compute sel = {a,b,c}.
  - y <= (8'h01 << sel), XORed with 8'hFF when ACTIVE_LOW = 1.
  - valid <= 1.
- Idle: when rst = 0 and en = 0 at an edge, y <= IDLE and valid <= 0. The output is not held from the previous cycle.
- Latency: exactly 1 cycle from sampled inputs to y/valid.
  - Back-to-back codes with en held high produce a new one-hot word every cycle. There are no bubbles.
- Invariant: whenever valid = 1, exactly one bit of y is at the active level. Whenever valid = 0, y == IDLE.
- Reset mid-operation: the output returns to IDLE/valid = 0 at the first edge with rst = 1, regardless of en or select.
  - Decoding resumes on the first edge after rst deasserts with en = 1.
- X/Z on a, b or c while en = 1 is not permitted by users. The block does not need to filter it.

Optional Feature:
- Macro: DECODER_3_TO_8_SEEN_EN.
- When defined, the following ports are added:
  - Input seen_clr (1 bit).
  - Output seen (8 bits).
- seen behaviour:
  - seen is a sticky mask. Each edge with rst = 0 and en = 1 ORs the active-high one-hot decode of sel into seen.
  - seen_clr = 1 clears seen to 8'h00 on the edge. If a decode is registered on the same edge, that decode bit is still set, i.e. seen <= onehot(sel).
  - rst clears seen to 8'h00.
  - seen is always active-high, independent of ACTIVE_LOW.
  - seen lets a bench or monitor confirm full code coverage, which is 8'hFF.
- When not defined: the ports and logic are absent, and behaviour is identical to the base description.

Test Plan:
- Reset: rst = 1 for 2 cycles with en = 1, abc = 101 -> y = 8'h00, valid = 0. After release with en = 1, abc = 101 -> y = 8'h20, valid = 1 one cycle later.
- Full sweep, en = 1: abc = 000..111 in order, one code per cycle (also held 200 time units each) -> y = 01, 02, 04, 08, 10, 20, 40, 80, each exactly one cycle after its code is applied.
- Enable gating: decode abc = 011 (y = 08), then en = 0 -> y = 8'h00, valid = 0 next cycle. en = 1 with abc = 110 -> y = 8'h40.
- ACTIVE_LOW = 1 instance: reset -> y = 8'hFF. abc = 000 -> y = 8'hFE. abc = 111 -> y = 8'h7F. en = 0 -> y = 8'hFF.
- Reset mid-stream: sweeping codes each cycle, assert rst on the cycle abc = 100 -> y = 8'h00, valid = 0. The code is never output. The sweep continues correctly after release.
- With DECODER_3_TO_8_SEEN_EN:
  - Codes 000, 010, 111 -> seen = 8'h85.
  - Full sweep -> seen = 8'hFF.
  - seen_clr together with abc = 001 -> seen = 8'h02.
